// File: rtl/memory_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_pkg
// Description : Decoded control bit positions shared by the memory stage
//               and its load-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_stage_pkg;

    // Control vector bit positions (one-hot load kind, plus memory-access flags)
    localparam int I_MEM_R = 0;   // instruction reads memory (load)
    localparam int I_MEM_W = 1;   // instruction writes memory (store)
    localparam int I_LB    = 2;
    localparam int I_LBU   = 3;
    localparam int I_LH    = 4;
    localparam int I_LHU   = 5;
    localparam int I_LW    = 6;
    localparam int I_LWL   = 7;
    localparam int I_LWR   = 8;
    localparam int I_MAX   = 9;   // width of the control vector

    // True for any instruction that must wait for a memory response
    function automatic logic is_mem(input logic [I_MAX-1:0] ctrl);
        return ctrl[I_MEM_R] | ctrl[I_MEM_W];
    endfunction

endpackage : memory_stage_pkg
`default_nettype wire

// File: rtl/memory_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load-data alignment: byte/halfword extraction
//               with sign/zero extension and LWL/LWR merge with old rt.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import memory_stage_pkg::*;
(
    input  logic [I_MAX-1:0] i_ctrl,
    input  logic [1:0]       i_off,
    input  logic [31:0]      i_mem,
    input  logic [31:0]      i_rt,
    output logic [31:0]      o_data
);

    logic [31:0] w_shr;

    // Move the addressed byte/halfword down to bit 0 so extraction is uniform
    assign w_shr = i_mem >> {i_off, 3'b000};

    // Select the aligned value for the load kind held in the control vector
    always_comb begin
        o_data = i_mem;
        if (i_ctrl[I_LB]) begin
            o_data = {{24{w_shr[7]}}, w_shr[7:0]};
        end else if (i_ctrl[I_LBU]) begin
            o_data = {24'h000000, w_shr[7:0]};
        end else if (i_ctrl[I_LH]) begin
            o_data = {{16{w_shr[15]}}, w_shr[15:0]};
        end else if (i_ctrl[I_LHU]) begin
            o_data = {16'h0000, w_shr[15:0]};
        end else if (i_ctrl[I_LWL]) begin
            // Left part: memory bytes fill from the top, old rt keeps the low bytes
            case (i_off)
                2'd0:    o_data = (i_mem << 24) | (i_rt & 32'h00FF_FFFF);
                2'd1:    o_data = (i_mem << 16) | (i_rt & 32'h0000_FFFF);
                2'd2:    o_data = (i_mem << 8)  | (i_rt & 32'h0000_00FF);
                default: o_data = i_mem;
            endcase
        end else if (i_ctrl[I_LWR]) begin
            // Right part: memory bytes fill from the bottom, old rt keeps the high bytes
            case (i_off)
                2'd0:    o_data = i_mem;
                2'd1:    o_data = (i_mem >> 8)  | (i_rt & 32'hFF00_0000);
                2'd2:    o_data = (i_mem >> 16) | (i_rt & 32'hFFFF_0000);
                default: o_data = (i_mem >> 24) | (i_rt & 32'hFFFF_FF00);
            endcase
        end
    end

endmodule : load_align
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : One-entry memory pipeline stage. Holds one instruction from
//               execute, waits for the data-memory response for loads and
//               stores, and drives the register-file write and forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    // data memory response
    input  logic             data_data_ok,
    input  logic [31:0]      data_rdata,
    // from execute
    output logic             ready_o,
    input  logic             valid_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      inst_i,
    input  logic [I_MAX-1:0] ctrl_i,
    input  logic [31:0]      result_i,
    input  logic [31:0]      eaddr_i,
    input  logic [31:0]      rdata2_i,
    input  logic [4:0]       waddr_i,
    // forwarding
    output logic [4:0]       wb_fwd_addr,
    output logic [31:0]      wb_fwd_data,
    output logic             wb_fwd_ok,
    // register file
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    // debug trace
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_wen,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_pc;
    logic [31:0]       r_inst;
    logic [I_MAX-1:0]  r_ctrl;
    logic [31:0]       r_result;
    logic [31:0]       r_eaddr;
    logic [31:0]       r_rdata2;
    logic [4:0]        r_waddr;

    logic              w_retire;
    logic              w_accept;
    logic              w_is_load;
    logic              w_is_store;
    logic [31:0]       w_load_data;
    logic [31:0]       w_wdata;

    assign w_is_load  = r_ctrl[I_MEM_R];
    assign w_is_store = r_ctrl[I_MEM_W];

    // The held instruction leaves this cycle: non-memory ops at once, memory ops on response
    assign w_retire = (r_state == S_BUSY) || ((r_state == S_WAIT) && data_data_ok);
    assign ready_o  = (r_state == S_EMPTY) || w_retire;
    assign w_accept = valid_i && ready_o;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a new instruction takes priority so accept-on-retire leaves no bubble
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = is_mem(ctrl_i) ? S_WAIT : S_BUSY;
        end else if (w_retire) begin
            w_state_nxt = S_EMPTY;
        end
    end

    // Holding register: capture every execute field on accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc     <= 32'h0;
            r_inst   <= 32'h0;
            r_ctrl   <= '0;
            r_result <= 32'h0;
            r_eaddr  <= 32'h0;
            r_rdata2 <= 32'h0;
            r_waddr  <= 5'd0;
        end else if (w_accept) begin
            r_pc     <= pc_i;
            r_inst   <= inst_i;
            r_ctrl   <= ctrl_i;
            r_result <= result_i;
            r_eaddr  <= eaddr_i;
            r_rdata2 <= rdata2_i;
            r_waddr  <= waddr_i;
        end
    end

    load_align u_load_align (
        .i_ctrl (r_ctrl),
        .i_off  (r_eaddr[1:0]),
        .i_mem  (data_rdata),
        .i_rt   (r_rdata2),
        .o_data (w_load_data)
    );

    assign w_wdata = w_is_load ? w_load_data : r_result;

    // Write-back: one-cycle write on retire; stores never write the register file
    assign rf_we    = w_retire && (r_waddr != 5'd0) && !w_is_store;
    assign rf_waddr = r_waddr;
    assign rf_wdata = w_wdata;

    // Forwarding: a pending load's data is only final once its response is present
    always_comb begin
        wb_fwd_ok = 1'b0;
        case (r_state)
            S_BUSY:  wb_fwd_ok = 1'b1;
            S_WAIT:  wb_fwd_ok = w_is_load ? data_data_ok : 1'b1;
            default: wb_fwd_ok = 1'b0;
        endcase
    end

    assign wb_fwd_addr = (r_state != S_EMPTY) ? r_waddr : 5'd0;
    assign wb_fwd_data = w_wdata;

    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule : memory_stage
`default_nettype wire

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have no parameters; ctrl width is `I_MAX from common.vh.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 data_data_ok  in  1  memory response for the oldest outstanding load or store.
REQ-005 data_rdata  in  32  load data, valid with data_data_ok.
REQ-006 ready_o  out  1  stage can accept from execute this cycle.
REQ-007 valid_i  in  1  execute output valid.
REQ-008 pc_i, inst_i  in  32 each  instruction PC and word.
REQ-009 ctrl_i  in  `I_MAX  decoded control bits.
REQ-010 result_i  in  32  ALU, LUI, link or HI/LO result.
REQ-011 eaddr_i  in  32  unaligned effective address.
REQ-012 rdata2_i  in  32  old rt value, used for LWL/LWR merge.
REQ-013 waddr_i  in  5  destination register; 0 = no write.
REQ-014 wb_fwd_addr  out  5  destination of the held instruction, 0 if none.
REQ-015 wb_fwd_data  out  32  final write data.
REQ-016 wb_fwd_ok  out  1  wb_fwd_data is final.
REQ-017 rf_we  out  1  register-file write enable.
REQ-018 rf_waddr  out  5  register-file write address.
REQ-019 rf_wdata  out  32  register-file write data.
REQ-020 debug_wb_pc  out  32  retiring PC.
REQ-021 debug_wb_rf_wen  out  4  {4{rf_we}}.
REQ-022 debug_wb_rf_wnum  out  5  equals rf_waddr.
REQ-023 debug_wb_rf_wdata  out  32  equals rf_wdata.

Function
REQ-024 One-entry holding register; FSM states EMPTY, BUSY, WAIT.
- EMPTY -> BUSY on accept of a non-memory instruction.
- EMPTY -> WAIT on accept of a memory instruction (I_MEM_R or I_MEM_W).
REQ-025 Accept occurs when valid_i && ready_o; all *_i fields are latched on that edge.
REQ-026 Retire occurs when the state is BUSY, or when it is WAIT && data_data_ok.
REQ-027 ready_o SHALL equal (state==EMPTY) || retire, so accept and retire can happen in the same cycle with no bubble.
REQ-028 On retire with no accept, the next state is EMPTY; on retire with accept, the next state is chosen from the new instruction.
REQ-029 data_data_ok SHALL be ignored in EMPTY and BUSY; the earliest response is the cycle after accept.
REQ-030 rf_we SHALL equal retire && waddr!=0; it is combinational, with a one-cycle write.
REQ-031 Stores SHALL retire on data_data_ok and never assert rf_we.
REQ-032 Write data selection:
- Loads: load-aligned data_rdata.
- Otherwise: result.
REQ-033 Load alignment uses off = eaddr[1:0] and m = data_rdata.
- LB/LBU: byte m[8*off+7:8*off], sign- or zero-extended to 32.
- LH/LHU: halfword m[8*off+15:8*off], sign- or zero-extended; off is 0 or 2.
- LW: m.
- LWL: (m << 8*(3-off)) | (rdata2 & (32'hFFFFFFFF >> 8*(off+1))); the mask is 0 when off=3.
- LWR: (m >> 8*off) | (rdata2 & ~(32'hFFFFFFFF >> 8*off)).
REQ-034 wb_fwd_addr SHALL be the held waddr when state!=EMPTY, else 0.
REQ-035 wb_fwd_ok SHALL be 1 in BUSY and in WAIT-for-a-store, and equal data_data_ok in WAIT-for-a-load; wb_fwd_data SHALL equal rf_wdata.
REQ-036 debug_wb_pc SHALL equal the held pc.

Reset
REQ-037 While resetn=0: state=EMPTY, all held registers 0, every output 0 except ready_o=1.
REQ-038 A reset asserted during WAIT SHALL discard the instruction; a later data_data_ok in EMPTY SHALL be ignored.

Structure
REQ-039 The I_* ctrl bit indices and I_MAX SHALL come from the shared common.vh; the FSM state encodings are local to memory_stage.
REQ-040 Sub-module load_align (combinational) SHALL implement REQ-033.

Verification
REQ-041 ADDU to r5, result 0x1234: retires the next cycle with rf_we=1, wnum=5, wdata=0x1234, wb_fwd_ok=1 throughout.
REQ-042 LB with eaddr=0x...2 and rdata=0x00800000: data_ok arrives after 3 cycles, ready_o=0 while waiting, then wdata=0xFFFFFF80; LBU gives 0x00000080.
REQ-043 LWL with off=1, m=0xAABBCCDD, rt=0x11223344: wdata=0xCCDD3344; LWR with off=1 and the same inputs: wdata=0x11AABBCC.
REQ-044 SW followed back-to-back by a non-memory instruction: SW retires on data_ok with rf_we=0, and the second instruction is accepted in the same cycle.
REQ-045 resetn pulsed low during WAIT, then data_data_ok=1: no rf_we, state stays EMPTY, ready_o=1.
REQ-046 waddr=0 instruction: retires with rf_we=0 and wb_fwd_addr=0.
